// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner: fetches one word at a time over a req/gnt/rvalid port,
// presents it to decode, and applies jump redirects (squashing wrong-path fetches).
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            trap_misaligned,
  output logic [XLEN-1:0] trap_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_TRAP  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
  logic              trap_q, trap_d;
  logic [XLEN-1:0]   trap_addr_q, trap_addr_d;
  logic [XLEN-1:0]   tgt_s;

  // JALR targets arrive with bit0 possibly set; only bit1 makes them misaligned.
  assign tgt_s = redirect_pc & {{(XLEN-1){1'b1}}, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    trap_d      = trap_q;
    trap_addr_d = trap_addr_q;
    if (redirect_valid && tgt_s[1] && (state_q != S_TRAP)) begin
      trap_d      = 1'b1;
      trap_addr_d = tgt_s;
      state_d     = S_TRAP;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_valid) begin
            pc_d = tgt_s;
          end else begin
            pc_d = pc_q;
          end
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (redirect_valid) begin
            pc_d = tgt_s;
            if (imem_gnt) begin
              kill_d  = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_FETCH;
            end
          end else if (imem_gnt) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_d = tgt_s;
            if (imem_rvalid) begin
              kill_d  = 1'b0;
              state_d = S_FETCH;
            end else begin
              kill_d  = 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_FETCH;
            end else begin
              instr_d    = imem_rdata;
              instr_pc_d = pc_q;
              state_d    = S_HOLD;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          // A redirect beats the handshake: the held word is wrong-path.
          if (redirect_valid) begin
            pc_d    = tgt_s;
            state_d = S_FETCH;
          end else if (instr_ready) begin
            pc_d    = pc_q + XLEN'(4);
            state_d = S_FETCH;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_TRAP: begin
          state_d = S_TRAP;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    imem_req        = 1'b0;
    imem_addr       = '0;
    instr_valid     = 1'b0;
    if (state_q == S_FETCH) begin
      imem_req  = 1'b1;
      imem_addr = pc_q;
    end else begin
      imem_req  = 1'b0;
      imem_addr = '0;
    end
    if (state_q == S_HOLD) begin
      instr_valid = 1'b1;
    end else begin
      instr_valid = 1'b0;
    end
    instr           = instr_q;
    instr_pc        = instr_pc_q;
    trap_misaligned = trap_q;
    trap_addr       = trap_addr_q;
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized bench: a memory responder, a program-order reference model feeding a
// scoreboard queue, and a monitor that checks every word presented to decode.
module tb_pc_fetch_sequencer;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, redirect_valid, trap_misaligned;
  logic [31:0] instr, instr_pc, redirect_pc, trap_addr;

  pc_fetch_sequencer #(.RESET_PC(RPC), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_misaligned(trap_misaligned),
    .trap_addr(trap_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pres  = 0;
  int mode    = 1;   // responder: 1 immediate, 2 random, 3 grant but never respond
  int cyc     = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        trapped;
  logic        s_v, s_req, s_gnt;
  logic [31:0] s_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Program-order model: next word decode should see, given what was driven this cycle.
  task automatic model_update();
    logic [31:0] t;
    if (!rst && !trapped) begin
      if (redirect_valid) begin
        t = redirect_pc & 32'hFFFF_FFFE;
        exp_q.delete();
        if (t[1]) begin
          trapped = 1'b1;
        end else begin
          exp_pc = t;
          exp_q.push_back(t);
        end
      end else if (s_v && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        exp_q.push_back(exp_pc);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_v = instr_valid; s_req = imem_req; s_addr = imem_addr; s_gnt = imem_gnt;
    @(posedge clk);
    #1;
    model_update();
    cyc++;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(RPC);
    exp_pc  = RPC;
    trapped = 1'b0;
    repeat (3) step();
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Memory responder: one word per grant after a random delay, data derived from address.
  initial begin
    logic        c_req, c_gnt, c_rv, c_redir, outst;
    logic [31:0] c_addr, oaddr;
    int          dly;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    outst = 1'b0; oaddr = 32'h0; dly = 0;
    forever begin
      @(negedge clk);
      c_req = imem_req; c_addr = imem_addr; c_gnt = imem_gnt;
      c_rv = imem_rvalid; c_redir = redirect_valid;
      @(posedge clk);
      #1;
      if (rst) begin
        outst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      end else begin
        if (c_rv) outst = 1'b0;
        if (c_req && c_gnt) begin
          outst = 1'b1;
          oaddr = c_addr;
          dly   = (mode == 1) ? 0 : ((mode == 3) ? 1000000 : int'($urandom_range(0, 3)));
        end
        if (imem_req && outst) begin
          n_tests++; n_fail++;
          $display("FAIL second_outstanding: req at %h while %h outstanding", imem_addr, oaddr);
        end
        if (c_req && !c_gnt && !c_redir && !trapped) begin
          check("req_held", {31'h0, imem_req}, 32'h1);
          check("addr_held", imem_addr, c_addr);
        end
        imem_gnt = imem_req && ((mode != 2) || ($urandom_range(0, 1) == 1));
        if (outst && dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(oaddr);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = $urandom;
          if (outst) dly--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every new presentation and checks it while held.
  initial begin
    logic        prev_v, prev_rdy, prev_redir, prev_rst;
    logic [31:0] cur_e;
    prev_v = 1'b0; prev_rdy = 1'b0; prev_redir = 1'b0; prev_rst = 1'b1; cur_e = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (instr_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_instr: pc %h presented, none expected", instr_pc);
          end else begin
            cur_e = exp_q.pop_front();
            check("instr_pc", instr_pc, cur_e);
            check("instr_data", instr, mem_word(cur_e));
            n_pres++;
          end
        end else if (instr_valid && prev_v) begin
          check("hold_pc", instr_pc, cur_e);
          check("hold_data", instr, mem_word(cur_e));
        end
        if (prev_v && !instr_valid && !prev_rdy && !prev_redir && !prev_rst) begin
          n_tests++; n_fail++;
          $display("FAIL valid_dropped: instr_valid fell without ready, got 0 expected 1");
        end
      end
      prev_v = instr_valid; prev_rdy = instr_ready; prev_redir = redirect_valid; prev_rst = rst;
    end
  end

  initial begin
    int          nreq, nval, base, guard;
    int          req_c[3], val_c[3];
    logic [31:0] req_a[3];
    logic [31:0] t;
    logic        pv;
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    exp_pc = RPC; trapped = 1'b0;
    #3;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_trap", {31'h0, trap_misaligned}, 32'h0);
    check("rst_trap_addr", trap_addr, 32'h0);

    // Immediate memory, decode always ready: sequential fetch and 2-cycle latency.
    mode = 1; instr_ready = 1'b1;
    do_reset();
    nreq = 0; nval = 0; pv = 1'b0;
    repeat (15) begin
      step();
      if (s_req && nreq < 3) begin req_a[nreq] = s_addr; req_c[nreq] = cyc - 1; nreq++; end
      if (s_v && !pv && nval < 3) begin val_c[nval] = cyc - 1; nval++; end
      pv = s_v;
    end
    check("seq_req_count", nreq, 3);
    check("seq_val_count", nval, 3);
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", req_a[i], RPC + 32'(4 * i));
      check("seq_latency", val_c[i] - req_c[i], 32'd2);
    end

    // Random grants, delays, back-pressure and redirects (including wrap near 2^32).
    mode = 2;
    base = n_pres;
    for (int i = 0; i < 3000; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8;
      else t = 32'($urandom_range(0, 255)) << 2;
      redirect_pc = t | 32'($urandom_range(0, 1));
      step();
    end
    redirect_valid = 1'b0; instr_ready = 1'b1;
    repeat (10) step();
    check("random_presentations", {31'h0, (n_pres - base) >= 100}, 32'h1);

    // Odd JALR target is fetched aligned; bit1 set traps permanently.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0401;
    step();
    redirect_valid = 1'b0;
    base = n_pres;
    repeat (30) step();
    check("odd_target_fetched", {31'h0, (n_pres - base) >= 1}, 32'h1);
    check("odd_no_trap", {31'h0, trap_misaligned}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0402;
    step();
    redirect_valid = 1'b0;
    check("trap_flag", {31'h0, trap_misaligned}, 32'h1);
    check("trap_addr", trap_addr, 32'h0000_0402);
    for (int i = 0; i < 10; i++) begin
      redirect_valid = ($urandom_range(0, 1) == 1);
      redirect_pc    = 32'($urandom_range(0, 255)) << 2;
      step();
      check("trap_no_req", {31'h0, imem_req}, 32'h0);
      check("trap_no_valid", {31'h0, instr_valid}, 32'h0);
      check("trap_sticky", {31'h0, trap_misaligned}, 32'h1);
    end
    redirect_valid = 1'b0;

    // Reset while a fetch is outstanding returns to RESET_PC.
    mode = 3;
    do_reset();
    guard = 0;
    do begin step(); guard++; end while (!(s_req && s_gnt) && guard < 10);
    check("wait_reached", {31'h0, s_req && s_gnt}, 32'h1);
    step();
    check("wait_no_req", {31'h0, imem_req}, 32'h0);
    mode = 1;
    do_reset();
    check("rst2_trap", {31'h0, trap_misaligned}, 32'h0);
    guard = 0;
    do begin step(); guard++; end while (!s_req && guard < 10);
    check("rst2_req_seen", {31'h0, s_req}, 32'h1);
    check("rst2_addr", s_addr, RPC);
    base = n_pres;
    repeat (10) step();
    check("rst2_presented", {31'h0, (n_pres - base) >= 1}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
